// File: rtl/scan_pkg.sv
// Shared types and constants for the 8x8 LED row scanner.
// Holds the scan FSM state encoding and the display geometry.
package scan_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// Gated 3-to-8 one-hot decoder for the LED row drivers.
// Output is all zeros whenever en is low.
module decoder_3_to_8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  // one-hot select, forced dark when disabled
  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/row_scan_controller.sv
// Time-multiplexed row scanner for the 8x8 LED display.
// Blanks between rows and swaps frames only at frame boundaries.
module row_scan_controller
  import scan_pkg::*;
#(
  parameter int ROW_TICKS   = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 update,
  input  logic [ROWS*COLS-1:0] cells,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic [2:0]           row_index,
  output logic                 frame_done
);

  localparam int CW =
    $clog2(max_int(ROW_TICKS, BLANK_TICKS) + 1);
  localparam logic [CW-1:0] ROW_LAST =
    CW'(ROW_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_TICKS - 1);

  scan_state_e          state_q, state_d;
  logic [2:0]           row_q, row_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ROWS*COLS-1:0] active_q, active_d;
  logic [ROWS*COLS-1:0] pending_q, pending_d;
  logic                 pend_v_q, pend_v_d;
  logic                 done_q, done_d;
  logic                 boundary;

  // scan sequencing: IDLE -> BLANK -> DRIVE -> BLANK ...
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    boundary = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          row_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == ROW_LAST) begin
            state_d  = BLANK;
            cnt_d    = '0;
            row_d    = row_q + 1'b1;
            done_d   = (row_q == 3'd7);
            boundary = (row_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // frame buffering: direct load when idle, swap only at boundary
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (state_q == IDLE) begin
      if (update) begin
        active_d = cells;
        pend_v_d = 1'b0;
      end
    end else if (boundary) begin
      if (update) begin
        active_d = cells;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        active_d = pending_q;
        pend_v_d = 1'b0;
      end
    end else if (update) begin
      pending_d = cells;
      pend_v_d  = 1'b1;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      done_q    <= done_d;
    end
  end

  decoder_3_to_8 u_row_dec (
    .en  (state_q == DRIVE),
    .sel (row_q),
    .dec (rows)
  );

  // column data for the driven row, dark otherwise
  always_comb begin
    cols = '0;
    if (state_q == DRIVE) cols = active_q[row_q*COLS +: COLS];
  end

  assign row_index  = row_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_row_scan_controller.sv
// Scoreboard bench for row_scan_controller (ROW_TICKS=4, BLANK_TICKS=2).
// Expected per-cycle outputs are queued as stimulus is planned.
module tb_row_scan_controller;

  localparam int RT = 4;
  localparam int BT = 2;
  localparam int FL = 8 * (RT + BT);

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        update;
  logic [63:0] cells;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [2:0]  row_index;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] DIAG = 64'h8040201008040201;
  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [63:0] PAT5 = {32{2'b01}};
  localparam logic [63:0] PATA = {32{2'b10}};
  localparam logic [63:0] PATF = {8{8'h0F}};
  localparam logic [63:0] PATX = 64'h0123456789ABCDEF;

  row_scan_controller #(
    .ROW_TICKS   (RT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .update     (update),
    .cells      (cells),
    .rows       (rows),
    .cols       (cols),
    .row_index  (row_index),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // queue the first n cycles of a frame as seen from its first blank
  task automatic push_frame(input logic [63:0] f,
                            input bit fd_first, input int n);
    exp_t e;
    int k;
    k = 0;
    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < BT + RT; t++) begin
        if (k < n) begin
          e.idx = 3'(r);
          e.fd  = fd_first && (k == 0);
          if (t < BT) begin
            e.rows = 8'h00;
            e.cols = 8'h00;
          end else begin
            e.rows = 8'(1 << r);
            e.cols = f[r*8 +: 8];
          end
          sb.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; ena = 1'b1; update = 1'b0; cells = '0;
    push_idle(3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      e = sb.pop_front();
      if ({rows, cols, row_index, frame_done} !==
          {e.rows, e.cols, e.idx, e.fd}) begin
        errors++;
        $display("FAIL reset k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                 k, rows, cols, row_index, frame_done,
                 e.rows, e.cols, e.idx, e.fd);
      end
      if (k == 1) rst = 1'b0;
    end
    ena = 1'b0;
  endtask

  task automatic test_scan_order();
    exp_t e;
    @(negedge clk);
    cells = DIAG; update = 1'b1;
    @(negedge clk);
    update = 1'b0; cells = '0; ena = 1'b1;
    push_frame(DIAG, 1'b0, FL);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++;
      e = sb.pop_front();
      if ({rows, cols, row_index, frame_done} !==
          {e.rows, e.cols, e.idx, e.fd}) begin
        errors++;
        $display("FAIL scan k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                 k, rows, cols, row_index, frame_done,
                 e.rows, e.cols, e.idx, e.fd);
      end
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    push_frame(DIAG, 1'b1, FL);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++;
      e = sb.pop_front();
      if ({rows, cols, row_index, frame_done} !==
          {e.rows, e.cols, e.idx, e.fd}) begin
        errors++;
        $display("FAIL tear k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                 k, rows, cols, row_index, frame_done,
                 e.rows, e.cols, e.idx, e.fd);
      end
      if (k == 3 * (RT + BT) + BT) begin
        update = 1'b1; cells = ONES;
      end else if (update) begin
        update = 1'b0; cells = '0;
      end
    end
  endtask

  task automatic test_boundary_update();
    exp_t e;
    push_frame(ONES, 1'b1, FL);
    push_frame(PATA, 1'b1, FL);
    push_frame(PATA, 1'b1, FL);
    for (int k = 0; k < 3 * FL; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bound k=%0d queue empty", k);
      end else begin
        e = sb.pop_front();
        if ({rows, cols, row_index, frame_done} !==
            {e.rows, e.cols, e.idx, e.fd}) begin
          errors++;
          $display("FAIL bound k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                   k, rows, cols, row_index, frame_done,
                   e.rows, e.cols, e.idx, e.fd);
        end
      end
      if (k == 14) begin
        update = 1'b1; cells = PAT5;
      end else if (k == FL - 1) begin
        update = 1'b1; cells = PATA;
      end else begin
        update = 1'b0; cells = '0;
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int cut;
    cut = 5 * (RT + BT) + BT + 2;
    push_frame(PATA, 1'b1, cut);
    push_idle(5);
    push_frame(PATA, 1'b0, FL);
    for (int k = 0; k < cut + 5 + FL; k++) begin
      @(negedge clk);
      checks++;
      e = sb.pop_front();
      if ({rows, cols, row_index, frame_done} !==
          {e.rows, e.cols, e.idx, e.fd}) begin
        errors++;
        $display("FAIL abort k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                 k, rows, cols, row_index, frame_done,
                 e.rows, e.cols, e.idx, e.fd);
      end
      if (k == 8) begin
        update = 1'b1; cells = PATX;
      end else begin
        update = 1'b0; cells = '0;
      end
      if (k == cut - 1) ena = 1'b0;
      if (k == cut + 4) ena = 1'b1;
    end
  endtask

  task automatic test_blank_gap();
    exp_t e;
    logic [7:0] prev;
    int zrun;
    prev = 8'h80;
    zrun = 0;
    push_frame(PATX, 1'b1, FL);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++;
      e = sb.pop_front();
      if ({rows, cols, row_index, frame_done} !==
          {e.rows, e.cols, e.idx, e.fd}) begin
        errors++;
        $display("FAIL gap k=%0d got r=%h c=%h i=%0d d=%b want r=%h c=%h i=%0d d=%b",
                 k, rows, cols, row_index, frame_done,
                 e.rows, e.cols, e.idx, e.fd);
      end
      if (rows == 8'h00) begin
        zrun++;
      end else begin
        if (prev == 8'h00) begin
          checks++;
          if (zrun !== BT) begin
            errors++;
            $display("FAIL gap_len k=%0d got %0d want %0d",
                     k, zrun, BT);
          end
        end else begin
          checks++;
          if (rows !== prev) begin
            errors++;
            $display("FAIL gap_adj k=%0d got %h after %h want %h",
                     k, rows, prev, prev);
          end
        end
        zrun = 0;
      end
      prev = rows;
    end
    ena = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_boundary_update();
    test_abort();
    test_blank_gap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
